// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
//   Unsigned W x W multiplier built around one external full-adder cell.
//   Shift-and-add: each multiplier bit costs W bit-serial ADD cycles
//   (LSB first, registered carry) plus one SHIFT cycle that moves the
//   accumulator LSB into the vacated multiplier MSB. After W iterations
//   {acc, mplier} holds the 2W-bit product.
// Ports
//   clk, rst_n         clock, async active-low reset
//   start, a, b        request + operands (sampled only in IDLE)
//   fa_x/fa_y/fa_cin   drive to the external one_bit_adder
//   fa_z/fa_cout       sum / carry back from the adder
//   busy               high during ADD and SHIFT
//   done               one-cycle pulse, product valid
//   product            result register, held until the next result
module shift_add_mult_ctrl #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           fa_x,
  output logic           fa_y,
  output logic           fa_cin,
  input  logic           fa_z,
  input  logic           fa_cout,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     mcand_q, mcand_d;
  logic [W-1:0]     mplier_q, mplier_d;
  logic [W-1:0]     acc_q, acc_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    bitcnt_q, bitcnt_d;
  logic [CW-1:0]    itercnt_q, itercnt_d;
  logic [2*W-1:0]   product_q, product_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             fa_x_q, fa_x_d, fa_y_q, fa_y_d, fa_cin_q, fa_cin_d;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    bitcnt_d  = bitcnt_q;
    itercnt_d = itercnt_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d   = a;
          mplier_d  = b;
          acc_d     = '0;
          carry_d   = 1'b0;
          bitcnt_d  = '0;
          itercnt_d = '0;
          state_d   = S_ADD;
        end
      end
      S_ADD: begin
        // Sum bit enters at the top; mcand rotates so it is realigned
        // after W cycles.
        acc_d   = {fa_z, acc_q[W-1:1]};
        mcand_d = {mcand_q[0], mcand_q[W-1:1]};
        carry_d = fa_cout;
        if (bitcnt_q == LAST) begin
          bitcnt_d = '0;
          state_d  = S_SHIFT;
        end else begin
          bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      S_SHIFT: begin
        acc_d    = {carry_q, acc_q[W-1:1]};
        mplier_d = {acc_q[0], mplier_q[W-1:1]};
        carry_d  = 1'b0;
        if (itercnt_q == LAST) begin
          // Post-shift {acc, mplier}, built from the pre-shift registers.
          product_d = {carry_q, acc_q, mplier_q[W-1:1]};
          state_d   = S_DONE;
        end else begin
          itercnt_d = itercnt_q + 1'b1;
          state_d   = S_ADD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with
    // the state they describe and carry no combinational path from fa_z.
    busy_d   = (state_d == S_ADD) || (state_d == S_SHIFT);
    done_d   = (state_d == S_DONE);
    fa_x_d   = (state_d == S_ADD) & acc_d[0];
    fa_y_d   = (state_d == S_ADD) & mcand_d[0] & mplier_d[0];
    fa_cin_d = (state_d == S_ADD) & carry_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      bitcnt_q  <= '0;
      itercnt_q <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fa_x_q    <= 1'b0;
      fa_y_q    <= 1'b0;
      fa_cin_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      bitcnt_q  <= bitcnt_d;
      itercnt_q <= itercnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fa_x_q    <= fa_x_d;
      fa_y_q    <= fa_y_d;
      fa_cin_q  <= fa_cin_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign fa_x    = fa_x_q;
  assign fa_y    = fa_y_q;
  assign fa_cin  = fa_cin_q;

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
module tb_shift_add_mult_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // W=4 instance
  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       x4, y4, ci4, z4, co4, busy4, done4;
  logic [7:0] prod4;
  assign z4  = x4 ^ y4 ^ ci4;
  assign co4 = (x4 & y4) | (x4 & ci4) | (y4 & ci4);

  shift_add_mult_ctrl #(.W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .fa_x(x4), .fa_y(y4), .fa_cin(ci4), .fa_z(z4), .fa_cout(co4),
    .busy(busy4), .done(done4), .product(prod4));

  // W=8 instance
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        x8, y8, ci8, z8, co8, busy8, done8;
  logic [15:0] prod8;
  assign z8  = x8 ^ y8 ^ ci8;
  assign co8 = (x8 & y8) | (x8 & ci8) | (y8 & ci8);

  shift_add_mult_ctrl #(.W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .fa_x(x8), .fa_y(y8), .fa_cin(ci8), .fa_z(z8), .fa_cout(co8),
    .busy(busy8), .done(done8), .product(prod8));

  // One W=4 operation from IDLE; called at #1 after a posedge.
  task automatic run4(input logic [3:0] ai, input logic [3:0] bi, input int chg_at,
                      output logic [7:0] p, output int lat, output int nbusy,
                      output bit cin_bad, output bit y_seen, output bit hold_bad,
                      output bit pulse_bad);
    logic [7:0] prev;
    int cnt;
    prev = prod4; lat = -1; nbusy = 0; cin_bad = 0; y_seen = 0; hold_bad = 0;
    pulse_bad = 0; p = 'x;
    a4 = ai; b4 = bi; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cnt = 1;
    while (cnt < 200) begin
      if (done4) begin lat = cnt; p = prod4; break; end
      if (busy4) nbusy++;
      if (y4) y_seen = 1;
      if (busy4 && ((cnt - 1) % 5 == 0) && ci4) cin_bad = 1;
      if (prod4 !== prev) hold_bad = 1;
      if (cnt == chg_at) begin a4 = '0; b4 = '0; end
      @(posedge clk); #1;
      cnt++;
    end
    @(posedge clk); #1;
    if (done4 || busy4 || prod4 !== p) pulse_bad = 1;
  endtask

  task automatic run8(input logic [7:0] ai, input logic [7:0] bi,
                      output logic [15:0] p, output int lat);
    int cnt;
    lat = -1; p = 'x;
    a8 = ai; b8 = bi; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cnt = 1;
    while (cnt < 400) begin
      if (done8) begin lat = cnt; p = prod8; break; end
      @(posedge clk); #1;
      cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    tests++;
    if ({busy4, done4, x4, y4, ci4, prod4} !== 13'd0) begin
      fails++;
      $display("FAIL reset_state: got busy=%b done=%b fa=%b%b%b product=%h, want all 0",
               busy4, done4, x4, y4, ci4, prod4);
    end
  endtask

  task automatic test_max;
    logic [7:0] p; int lat, nb; bit cb, ys, hb, pb;
    run4(4'd15, 4'd15, -1, p, lat, nb, cb, ys, hb, pb);
    tests++; if (p !== 8'hE1) begin fails++; $display("FAIL max_product: got %h want e1", p); end
    tests++; if (lat !== 21) begin fails++; $display("FAIL max_latency: got %0d want 21", lat); end
    tests++; if (nb !== 20) begin fails++; $display("FAIL max_busy: got %0d want 20", nb); end
    tests++; if (cb !== 1'b0) begin fails++; $display("FAIL max_first_cin: got %b want 0", cb); end
    tests++; if (pb !== 1'b0) begin fails++; $display("FAIL max_done_pulse: got %b want 0", pb); end
  endtask

  task automatic test_zero_hold;
    logic [7:0] p; int lat, nb; bit cb, ys, hb, pb;
    run4(4'd5, 4'd3, -1, p, lat, nb, cb, ys, hb, pb);
    tests++; if (p !== 8'h0F) begin fails++; $display("FAIL five_by_three: got %h want 0f", p); end
    run4(4'd0, 4'd9, -1, p, lat, nb, cb, ys, hb, pb);
    tests++; if (p !== 8'h00) begin fails++; $display("FAIL zero_by_nine: got %h want 00", p); end
    tests++; if (ys !== 1'b0) begin fails++; $display("FAIL zero_fa_y: got %b want 0", ys); end
    tests++; if (hb !== 1'b0) begin fails++; $display("FAIL product_hold: got %b want 0", hb); end
  endtask

  task automatic test_back_to_back;
    int rise[$];
    int ndone;
    bit prev_busy;
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd6;
    prev_busy = busy4; ndone = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (busy4 && !prev_busy) rise.push_back(c);
      if (done4) begin
        ndone++;
        tests++;
        if (prod4 !== 8'd42) begin fails++; $display("FAIL b2b_product: got %0d want 42", prod4); end
      end
      prev_busy = busy4;
    end
    start4 = 1'b0;
    tests++;
    if (rise.size() < 3 || ndone < 3) begin
      fails++; $display("FAIL b2b_count: got %0d accepts %0d dones want >=3", rise.size(), ndone);
    end else begin
      for (int i = 1; i < rise.size(); i++) begin
        tests++;
        if (rise[i] - rise[i-1] != 22) begin
          fails++; $display("FAIL b2b_spacing: got %0d want 22", rise[i] - rise[i-1]);
        end
      end
    end
    for (int c = 0; c < 60 && (busy4 || done4); c++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
  endtask

  task automatic test_input_change;
    logic [7:0] p; int lat, nb; bit cb, ys, hb, pb;
    run4(4'd9, 4'd11, 3, p, lat, nb, cb, ys, hb, pb);
    tests++; if (p !== 8'd99) begin fails++; $display("FAIL input_change: got %0d want 99", p); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] p; int lat, nb, nd; bit cb, ys, hb, pb;
    start4 = 1'b1; a4 = 4'd12; b4 = 4'd13;
    @(posedge clk); #1;
    start4 = 1'b0;
    for (int i = 2; i <= 10; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy4, done4, x4, y4, ci4, prod4} !== 13'd0) begin
      fails++;
      $display("FAIL reset_mid: got busy=%b done=%b fa=%b%b%b product=%h, want all 0",
               busy4, done4, x4, y4, ci4, prod4);
    end
    nd = 0;
    repeat (3) begin @(posedge clk); #1; if (done4) nd++; end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (30) begin if (done4) nd++; @(posedge clk); #1; end
    tests++; if (nd !== 0) begin fails++; $display("FAIL reset_no_done: got %0d pulses want 0", nd); end
    run4(4'd12, 4'd13, -1, p, lat, nb, cb, ys, hb, pb);
    tests++; if (p !== 8'd156) begin fails++; $display("FAIL reset_fresh: got %0d want 156", p); end
  endtask

  task automatic test_sweep4;
    logic [7:0] p; int lat, nb; bit cb, ys, hb, pb;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run4(4'(i), 4'(j), -1, p, lat, nb, cb, ys, hb, pb);
        tests++;
        if (p !== 8'(i * j) || lat !== 21) begin
          fails++;
          $display("FAIL sweep4 %0d*%0d: got %0d lat %0d want %0d lat 21", i, j, p, lat, i * j);
        end
      end
    end
  endtask

  task automatic test_sweep8;
    logic [15:0] p; int lat;
    logic [7:0] ai, bi;
    for (int k = 0; k < 40; k++) begin
      ai = (k == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      bi = (k == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      run8(ai, bi, p, lat);
      tests++;
      if (p !== 16'(ai * bi) || lat !== 73) begin
        fails++;
        $display("FAIL sweep8 %0d*%0d: got %0d lat %0d want %0d lat 73", ai, bi, p, lat,
                 16'(ai * bi));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_max;
    test_zero_hold;
    test_back_to_back;
    test_input_change;
    test_reset_mid;
    test_sweep4;
    test_sweep8;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
